// File: rtl/mux_bist_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_bist_ctrl_pkg
//  Purpose  : Shared definitions for the 2:1 mux built-in self-test
//             controller: FSM state encoding, wire/vector counts and the
//             "no fault" index code.
//  Contents : state_t        - controller FSM states (3-bit encoding)
//             NUM_WIRES      - observed internal wires of the mux (9)
//             NUM_VECTORS    - exhaustive input vectors {I0,I1,S} (8)
//             FAULT_IDX_NONE - fault_idx value reported on a pass
//  Revision : 1.0 - initial release
// ============================================================================
package mux_bist_ctrl_pkg;

    localparam int          NUM_WIRES      = 9;
    localparam int          NUM_VECTORS    = 8;
    localparam logic [3:0]  FAULT_IDX_NONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage : mux_bist_ctrl_pkg
`default_nettype wire

// File: rtl/mux_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_bist_ctrl_if
//  Purpose  : Bundles the BIST request/status signals and the drive/observe
//             wires towards the 2:1 mux under test.
//  Signals  : start                - single-cycle self-test request
//             dut_s/dut_i0/dut_i1  - select and data drives to the mux
//             dut_obs[8:0]         - observed internal wires of the mux
//             busy/done/pass/fail  - run status and result flags
//             fault_idx[3:0]       - lowest mismatching wire, 4'hF on pass
//             stuck_val            - inferred stuck-at value of that wire
//  Modports : master - the BIST controller
//             slave  - the environment (requester plus mux under test)
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_bist_ctrl_if;
    import mux_bist_ctrl_pkg::*;

    logic                 start;
    logic                 dut_s;
    logic                 dut_i0;
    logic                 dut_i1;
    logic [NUM_WIRES-1:0] dut_obs;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic [3:0]           fault_idx;
    logic                 stuck_val;

    modport master (
        input  start,
        input  dut_obs,
        output dut_s,
        output dut_i0,
        output dut_i1,
        output busy,
        output done,
        output pass,
        output fail,
        output fault_idx,
        output stuck_val
    );

    modport slave (
        output start,
        output dut_obs,
        input  dut_s,
        input  dut_i0,
        input  dut_i1,
        input  busy,
        input  done,
        input  pass,
        input  fail,
        input  fault_idx,
        input  stuck_val
    );

endinterface : mux_bist_ctrl_if
`default_nettype wire

// File: rtl/mux_bist_ctrl_golden.sv
`default_nettype none
// ============================================================================
//  Module   : mux_golden_model
//  Purpose  : Combinational reference of the nine internal wires of a
//             gate-level 2:1 mux for a given {I0,I1,S} input vector.
//  Ports    : s_i, i0_i, i1_i     - select and data inputs of the vector
//             golden_o[8:0]       - expected wire values:
//                 [0]=I0 [1]=I1 [2..4]=S (fan-out branches) [5]=~S
//                 [6]=I1&S [7]=I0&~S [8]=mux output
//  Revision : 1.0 - initial release
// ============================================================================
module mux_golden_model
    import mux_bist_ctrl_pkg::*;
(
    input  wire logic                 s_i,
    input  wire logic                 i0_i,
    input  wire logic                 i1_i,
    output logic [NUM_WIRES-1:0]      golden_o
);

    logic w_and1;
    logic w_and0;

    assign w_and1 = i1_i & s_i;
    assign w_and0 = i0_i & ~s_i;

    assign golden_o[0] = i0_i;
    assign golden_o[1] = i1_i;
    assign golden_o[2] = s_i;
    assign golden_o[3] = s_i;
    assign golden_o[4] = s_i;
    assign golden_o[5] = ~s_i;
    assign golden_o[6] = w_and1;
    assign golden_o[7] = w_and0;
    assign golden_o[8] = w_and1 | w_and0;

endmodule : mux_golden_model
`default_nettype wire

// File: rtl/mux_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux_bist_ctrl
//  Purpose  : Exhaustive self-test of a 2:1 mux. Walks the eight vectors
//             {I0,I1,S}=0..7, waits SETTLE_CYCLES after each drive, compares
//             the nine observed wires against the golden model and stops at
//             the first mismatch, reporting the lowest failing wire and the
//             stuck-at value it implies.
//  Params   : SETTLE_CYCLES - wait cycles between drive and compare (1..15)
//  Ports    : clk   - clock, rising edge active
//             rst_n - asynchronous active-low reset
//             bus   - mux_bist_ctrl_if.master (request, drives, observes,
//                     status and result)
//  Revision : 1.0 - initial release
// ============================================================================
module mux_bist_ctrl
    import mux_bist_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)(
    input  wire logic        clk,
    input  wire logic        rst_n,
    mux_bist_ctrl_if.master  bus
);

    state_t                 state_q;
    logic [2:0]             vec_q;
    logic [3:0]             cnt_q;
    logic                   dut_s_q;
    logic                   dut_i0_q;
    logic                   dut_i1_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   fail_q;
    logic [3:0]             fault_idx_q;
    logic                   stuck_val_q;
    logic                   result_pass_q;

    logic [NUM_WIRES-1:0]   w_golden;
    logic [NUM_WIRES-1:0]   w_mismatch;
    logic [3:0]             w_fault_idx;
    logic                   w_stuck_val;

    // Golden values for the vector currently held in vec_q; vec_q is
    // stable from APPLY through CHECK, so the compare sees the right vector.
    mux_golden_model u_golden (
        .s_i      (vec_q[0]),
        .i0_i     (vec_q[2]),
        .i1_i     (vec_q[1]),
        .golden_o (w_golden)
    );

    assign w_mismatch = bus.dut_obs ^ w_golden;

    // Lowest mismatching wire wins: scanning downwards lets the lowest
    // index overwrite any higher one.
    always_comb begin
        w_fault_idx = FAULT_IDX_NONE;
        w_stuck_val = 1'b0;
        for (int i = NUM_WIRES - 1; i >= 0; i--) begin
            if (w_mismatch[i]) begin
                w_fault_idx = 4'(i);
                w_stuck_val = ~w_golden[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vec_q         <= 3'd0;
            cnt_q         <= 4'd0;
            dut_s_q       <= 1'b0;
            dut_i0_q      <= 1'b0;
            dut_i1_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fault_idx_q   <= FAULT_IDX_NONE;
            stuck_val_q   <= 1'b0;
            result_pass_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q       <= ST_APPLY;
                        vec_q         <= 3'd0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        fail_q        <= 1'b0;
                        fault_idx_q   <= FAULT_IDX_NONE;
                        stuck_val_q   <= 1'b0;
                        result_pass_q <= 1'b0;
                    end else if (state_q == ST_DONE) begin
                        // Flags publish one cycle into DONE so done, pass
                        // and fail always appear together as one result.
                        done_q <= 1'b1;
                        pass_q <= result_pass_q;
                        fail_q <= ~result_pass_q;
                    end
                end

                ST_APPLY: begin
                    dut_i0_q <= vec_q[2];
                    dut_i1_q <= vec_q[1];
                    dut_s_q  <= vec_q[0];
                    cnt_q    <= 4'(SETTLE_CYCLES);
                    state_q  <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    // <= 1 rather than == 1 keeps a zero count from spinning.
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_CHECK: begin
                    if (|w_mismatch) begin
                        fault_idx_q   <= w_fault_idx;
                        stuck_val_q   <= w_stuck_val;
                        result_pass_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_DONE;
                    end else if (vec_q == 3'(NUM_VECTORS - 1)) begin
                        result_pass_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_DONE;
                    end else begin
                        vec_q   <= vec_q + 3'd1;
                        state_q <= ST_APPLY;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_s     = dut_s_q;
    assign bus.dut_i0    = dut_i0_q;
    assign bus.dut_i1    = dut_i1_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.fault_idx = fault_idx_q;
    assign bus.stuck_val = stuck_val_q;

endmodule : mux_bist_ctrl
`default_nettype wire

// File: tb/tb_mux_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_bist_ctrl
//  Purpose  : Self-checking bench for mux_bist_ctrl. A behavioural 2:1 mux
//             with stuck-at masks answers the controller's drives; each run
//             pushes its hand-computed result into a scoreboard that a
//             monitor pops when done rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_bist_ctrl;
    import mux_bist_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mux_bist_ctrl_if bus ();

    mux_bist_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- mux under test with fault injection ----------------
    logic [8:0] stuck0_mask = 9'h000;
    logic [8:0] stuck1_mask = 9'h000;

    function automatic logic [8:0] mux_wires(input logic s, input logic i0, input logic i1);
        logic a1, a0;
        a1 = i1 & s;
        a0 = i0 & ~s;
        return {a1 | a0, a0, a1, ~s, s, s, s, i1, i0};
    endfunction

    assign bus.dut_obs = (mux_wires(bus.dut_s, bus.dut_i0, bus.dut_i1) & ~stuck0_mask) | stuck1_mask;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       ep;
        logic [3:0] idx;
        logic       stuck;
        int         lat;
        int         max_vec;
    } exp_t;

    exp_t sb_q[$];

    int n_tests  = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int t_start  = 0;
    int max_vec  = -1;
    logic done_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            max_vec   = -1;
            done_prev = 1'b0;
            busy_prev = 1'b0;
        end else begin
            // Skip the first busy cycle: drives still hold the previous run.
            if (bus.busy && busy_prev &&
                int'({bus.dut_i0, bus.dut_i1, bus.dut_s}) > max_vec)
                max_vec = int'({bus.dut_i0, bus.dut_i1, bus.dut_s});
            if (bus.done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fails++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    exp_t e;
                    logic ef;
                    e  = sb_q.pop_front();
                    ef = ~e.ep;
                    chk("latency",   cyc - t_start, e.lat);
                    chk("pass",      bus.pass,      e.ep);
                    chk("fail",      bus.fail,      ef);
                    chk("fault_idx", bus.fault_idx, e.idx);
                    chk("stuck_val", bus.stuck_val, e.stuck);
                    chk("max_vec",   max_vec,       e.max_vec);
                end
                max_vec = -1;
            end
            done_prev = bus.done;
            busy_prev = bus.busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dut_s"},     bus.dut_s,     0);
        chk({tag, "_dut_i0"},    bus.dut_i0,    0);
        chk({tag, "_dut_i1"},    bus.dut_i1,    0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_done"},      bus.done,      0);
        chk({tag, "_pass"},      bus.pass,      0);
        chk({tag, "_fail"},      bus.fail,      0);
        chk({tag, "_fault_idx"}, bus.fault_idx, 4'hF);
        chk({tag, "_stuck_val"}, bus.stuck_val, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t_start = cyc;
    endtask

    task automatic run(input logic [8:0] s0, input logic [8:0] s1,
                       input logic ep, input logic [3:0] eidx, input logic es,
                       input int elat, input int emax, input bit restart_mid);
        exp_t e;
        int   n;
        stuck0_mask = s0;
        stuck1_mask = s1;
        e.ep = ep; e.idx = eidx; e.stuck = es; e.lat = elat; e.max_vec = emax;
        sb_q.push_back(e);
        pulse_start();
        chk("busy_after_start", bus.busy, 1);
        chk("done_cleared",     bus.done, 0);
        if (restart_mid) begin
            // Sampled at the 10th edge of the run; must be ignored.
            repeat (8) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            chk("busy_after_restart_pulse", bus.busy, 1);
        end
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_tests++;
            n_fails++;
            $display("FAIL done_timeout: got done=0 expected done within 100 cycles");
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fault-free: all 8 vectors, done 33 cycles after start sampled.
        run(9'h000, 9'h000, 1'b1, 4'hF, 1'b0, 33, 7, 1'b0);
        // wire 6 stuck-at-0: first seen at v=3, v=4 never driven.
        run(9'h040, 9'h000, 1'b0, 4'd6, 1'b0, 17, 3, 1'b0);
        // wire 5 stuck-at-1: first seen at v=1.
        run(9'h000, 9'h020, 1'b0, 4'd5, 1'b1, 9, 1, 1'b0);
        // wires 0 and 8 stuck-at-1: both fail at v=0, lowest index wins.
        run(9'h000, 9'h101, 1'b0, 4'd0, 1'b1, 5, 0, 1'b0);
        // wire 7 stuck-at-0: first 1 on I0&~S is v=4.
        run(9'h080, 9'h000, 1'b0, 4'd7, 1'b0, 21, 4, 1'b0);
        // wire 2 stuck-at-0: first seen at v=1.
        run(9'h004, 9'h000, 1'b0, 4'd2, 1'b0, 9, 1, 1'b0);

        // Abort during SETTLE of v=4, then a clean restart.
        stuck0_mask = 9'h000;
        stuck1_mask = 9'h000;
        pulse_start();
        repeat (18) @(negedge clk);
        chk("abort_vec", {bus.dut_i0, bus.dut_i1, bus.dut_s}, 3'd4);
        chk("abort_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run(9'h000, 9'h000, 1'b1, 4'hF, 1'b0, 33, 7, 1'b0);

        // Second start mid-run is ignored.
        run(9'h000, 9'h000, 1'b1, 4'hF, 1'b0, 33, 7, 1'b1);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule : tb_mux_bist_ctrl
`default_nettype wire

// File: doc/mux_bist_ctrl.md
MUX_BIST_CTRL -- requirements
Module: mux_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the number of wait cycles between applying a vector and sampling observed wires; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to run a full self-test; sampled only in IDLE.
REQ-005 dut_s  output  1  select drive to 2:1 mux under test.
REQ-006 dut_i0  output  1  data-0 drive to mux under test.
REQ-007 dut_i1  output  1  data-1 drive to mux under test.
REQ-008 dut_obs  input  9  observed internal wires of mux under test, bit order fixed by REQ-015.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-010 done  output  1  level, high in DONE; cleared when the next start is accepted.
REQ-011 pass  output  1  valid while done; high when all 8 vectors matched.
REQ-012 fail  output  1  valid while done; exact complement of pass.
REQ-013 fault_idx  output  4  index 0..8 of first mismatching wire; 4'hF when pass.
REQ-014 stuck_val  output  1  inferred stuck-at value, equal to inverted golden bit at fault_idx; 0 when pass.

Function
REQ-015 Golden wires per vector: g0=I0, g1=I1, g2=S, g3=S, g4=S, g5=~S, g6=I1&S, g7=I0&~S, g8=(I1&S)|(I0&~S).
REQ-016 Vector order: 3-bit counter v=0..7 mapped {I0,I1,S}=v (S is LSB), i.e. 000,001,010,...,111.
REQ-017 States: IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-018 IDLE: outputs dut_* low; start=1 -> APPLY with v=0, clear done/pass/fail, fault_idx=4'hF, stuck_val=0.
REQ-019 APPLY (1 cycle): register dut_* from v -> SETTLE, settle counter loaded with SETTLE_CYCLES.
REQ-020 SETTLE: decrement counter each cycle; at count 1 -> CHECK; dut_* held stable.
REQ-021 CHECK (1 cycle): compare dut_obs to golden of v; mismatch -> record lowest mismatching index in fault_idx, stuck_val=~golden[idx], fail -> DONE.
REQ-022 CHECK with match: v<7 -> v+1, APPLY; v=7 -> pass -> DONE.
REQ-023 Per-vector latency = SETTLE_CYCLES+2 cycles; full pass run: done rises 8*(SETTLE_CYCLES+2)+1 cycles after the start-sampling edge (33 with default).
REQ-024 Test stops at first failing vector; later vectors are not applied.
REQ-025 DONE: results and dut_* held; start=1 -> behaves as IDLE acceptance (REQ-018).
REQ-026 start while busy is ignored, no restart, no error.
REQ-027 Multiple simultaneous mismatches: only lowest index reported.
REQ-028 No wrap of v beyond 7; counter stops at 7.

Reset
REQ-029 rst_n low forces IDLE, v=0, settle counter 0, dut_*=0, busy=0, done=0, pass=0, fail=0, fault_idx=4'hF, stuck_val=0, immediately and independent of clk.
REQ-030 Reset mid-run aborts the test with no partial result retained; a new start after release runs from v=0.

Structure
REQ-031 Shared package holds state encoding, NUM_WIRES=9, NUM_VECTORS=8, FAULT_IDX_NONE=4'hF.
REQ-032 Golden computation in one combinational sub-module mux_golden_model (inputs s,i0,i1; output 9-bit golden); controller instantiates it once.

Verification
REQ-033 Fault-free mux model, start pulse -> done at cycle 33, pass=1, fail=0, fault_idx=F, stuck_val=0.
REQ-034 obs[6] stuck at 0 -> fails at v=3 (I1=1,S=1), fault_idx=6, stuck_val=0, v=4 never driven.
REQ-035 obs[5] stuck at 1 -> fails at v=1 (S=1), fault_idx=5, stuck_val=1.
REQ-036 obs[0] and obs[8] both stuck at 1 -> fails at v=0, fault_idx=0, stuck_val=1.
REQ-037 rst_n low during SETTLE of v=4 -> all outputs at reset values same instant; restart -> full pass in 33 cycles.
REQ-038 start pulsed again at cycle 10 of a run -> ignored; done still at cycle 33.
